mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port between the CPU's instruction-fetch requester and data-access requester.
- Selects one requester per address phase and holds that grant until the address is accepted.
- Records each accepted transaction's owner in an in-order ID FIFO and routes each returned data_ok/rdata back to that owner.
- Sits between the pipeline's inst/data request interfaces and the single memory/bridge port.

Parameters:
- OUTSTANDING, 4: maximum accepted-but-unreturned transactions; power of 2, range 2..16.
- OID_W, 2: log2(OUTSTANDING), width of the FIFO pointers.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- inst_req  in  1  fetch request valid
- inst_addr  in  32  fetch address (always a 4-byte read)
- inst_addr_ok  out  1  fetch address accepted this cycle
- inst_data_ok  out  1  fetch data returned this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request valid
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data address accepted this cycle
- data_data_ok  out  1  data response (read data, or write done)
- data_rdata  out  32  data read data
- mem_req  out  1  downstream request valid
- mem_wr  out  1  downstream write
- mem_size  out  2  downstream size
- mem_wstrb  out  4  downstream strobes
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_addr_ok  in  1  downstream address accepted
- mem_data_ok  in  1  downstream response
- mem_rdata  in  32  downstream read data

Behaviour:
- Handshakes:
  - Address phase completes in the cycle where mem_req & mem_addr_ok are both high.
  - One response per accepted request, in acceptance order; writes also receive a mem_data_ok.
- Arbitration state: IDLE / HOLD_I / HOLD_D.
  - IDLE: if the FIFO is not full, grant data when data_req is high, else grant inst when inst_req is high (fixed priority).
  - IDLE transitions: a grant with !mem_addr_ok goes to HOLD_x; acceptance stays in IDLE.
  - HOLD_x: the grant stays on requester x; mem_* fields come from x. The other requester is never forwarded.
  - HOLD_x returns to IDLE on mem_addr_ok.
  - If x drops req while in HOLD_x (a protocol violation): mem_req drops and the state returns to IDLE next cycle.
- mem_* driving:
  - mem_req = granted requester's req & !full & !reset.
  - Inst grant drives mem_wr = 0, mem_size = 2, mem_wstrb = 0, mem_wdata = 0.
  - Non-granted fields are don't-care, driven as 0.
- Address acknowledge: inst_addr_ok / data_addr_ok = mem_addr_ok & mem_req & (grant == that requester). This is combinational, same cycle.
- ID FIFO:
  - OUTSTANDING entries, 1-bit owner (0 = inst, 1 = data).
  - Push on address acceptance; pop on mem_data_ok.
  - Count register is OID_W+1 bits.
  - full = (count == OUTSTANDING). When full, mem_req stays 0 even if a pop occurs in the same cycle.
  - Simultaneous push and pop with count not full: count unchanged, both pointers advance.
  - Pointers wrap modulo OUTSTANDING.
- Response routing:
  - inst_data_ok = mem_data_ok & !empty & head == 0; data_data_ok likewise with head == 1.
  - inst_rdata and data_rdata both = mem_rdata.
  - mem_data_ok while empty is ignored: no pop, no *_data_ok.
- Latency: zero added cycles on either phase.
- Reset: state IDLE, count 0, pointers 0. While reset is high, mem_req, both *_addr_ok and both *_data_ok are 0. Reset mid-transaction discards all outstanding entries; late mem_data_ok after reset is ignored under the empty rule.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: IDLE arbitration is round-robin. A last_grant register (reset = data) selects the requester not granted last when both request. last_grant updates on each address acceptance.
- Undefined: fixed data-over-inst priority; no last_grant register.

Test Plan:
- Single fetch: inst_req with addr 0x1c000000, mem_addr_ok same cycle, mem_data_ok 2 cycles later with rdata 0x02800c0c -> inst_addr_ok cycle 0, inst_data_ok with 0x02800c0c at cycle 2, data_data_ok stays 0.
- Contention: both req high, mem_addr_ok = 1 -> data accepted first, inst next cycle; responses return D then I. With MEM_ARB_RR_EN and last_grant = data, inst goes first.
- Hold: inst granted, mem_addr_ok held low 3 cycles, data_req rises in cycle 1 -> mem_addr stays inst_addr until acceptance, then data is granted.
- Full: 4 accepts, no mem_data_ok -> mem_req = 0 in cycle 5. A pop in cycle 5 still blocks; the accept occurs in cycle 6.
- Write: data_wr = 1, wstrb 4'b0011, size 1, addr 0x8 -> mem_* mirror the inputs; the subsequent mem_data_ok yields data_data_ok.
- Reset with 3 outstanding -> after reset count = 0; a stray mem_data_ok produces no *_data_ok.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU fetch and data requesters onto one SRAM-like memory port and
// routes in-order responses back via an owner FIFO. Define MEM_ARB_RR_EN for round-robin.
module mem_port_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int OID_W       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD_I = 2'd1;
    localparam logic [1:0] HOLD_D = 2'd2;

    localparam logic [OID_W:0] FULL_CNT = (OID_W+1)'(OUTSTANDING);

    logic [1:0]       state_q, state_d;
    logic [OID_W:0]   count_q, count_d;
    logic [OID_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             owner_q [OUTSTANDING];

    logic full, empty, grant_inst, grant_data, accept, pop;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;  // 1 = data won the last accepted address phase
`endif

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        case (state_q)
            IDLE: begin
                if (!full) begin
`ifdef MEM_ARB_RR_EN
                    if (data_req && inst_req) begin
                        grant_data = !last_grant_q;
                        grant_inst = last_grant_q;
                    end else begin
                        grant_data = data_req;
                        grant_inst = inst_req && !data_req;
                    end
`else
                    grant_data = data_req;
                    grant_inst = inst_req && !data_req;
`endif
                end
            end
            HOLD_I:  grant_inst = 1'b1;
            HOLD_D:  grant_data = 1'b1;
            default: ;
        endcase
    end

    assign mem_req = ((grant_inst && inst_req) || (grant_data && data_req)) && !full && !reset;
    assign accept  = mem_req && mem_addr_ok;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (grant_data) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (grant_inst) begin
            mem_size  = 2'd2;
            mem_addr  = inst_addr;
        end
    end

    assign inst_addr_ok = accept && grant_inst;
    assign data_addr_ok = accept && grant_data;

    // Responses with nothing outstanding are stray and must not pop.
    assign pop          = mem_data_ok && !empty && !reset;
    assign inst_data_ok = pop && !owner_q[rd_ptr_q];
    assign data_data_ok = pop && owner_q[rd_ptr_q];
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_req && !mem_addr_ok) state_d = grant_data ? HOLD_D : HOLD_I;
            HOLD_I:  if (!inst_req || mem_addr_ok) state_d = IDLE;
            HOLD_D:  if (!data_req || mem_addr_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_q + OID_W'(accept);
            rd_ptr_q <= rd_ptr_q + OID_W'(pop);
        end
    end

    // NOTE: the owner storage has no reset; an entry is only read after its push writes it.
    always_ff @(posedge clk) begin
        if (accept) owner_q[wr_ptr_q] <= grant_data;
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset)       last_grant_q <= 1'b1;
        else if (accept) last_grant_q <= grant_data;
    end
`endif

endmodule
